// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: byte request/parity inputs and serial line/status outputs of the UART frame transmitter
interface uart_frame_tx_if;
   logic       send;
   logic [7:0] data_in;
   logic [1:0] parity_type;
   logic       tx_out;
   logic       busy;
   logic       ready;
   logic       done_flag;
   modport master (output send, data_in, parity_type, input tx_out, busy, ready, done_flag);
   modport slave (input send, data_in, parity_type, output tx_out, busy, ready, done_flag);
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: builds {stop, parity, data, start} and shifts it out LSB-first with its own baud divider
module uart_frame_tx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8
) (
   input logic             clock,
   input logic             reset,
   uart_frame_tx_if.slave  bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int FW = DATA_BITS + 3;
   localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [FW-1:0] sh_q, sh_d;
   logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic          tc, p;
   always_comb begin
      p  = bus.parity_type == 2'b10 ? ^bus.data_in : bus.parity_type == 2'b01 ? ~^bus.data_in : 1'b1;
      tc = cnt_q == TC;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         tx_d = 1'b1;
         if (bus.send) begin
            state_d = START;
            sh_d    = {1'b1, p, bus.data_in, 1'b0};
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
         end
      end else if (!tc) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         // tx always mirrors sh[0], so the bit about to shift in is sh[1]
         cnt_d = '0;
         sh_d  = {1'b1, sh_q[FW-1:1]};
         tx_d  = sh_q[1];
         case (state_q)
            START:   state_d = DATA;
            DATA: begin
               idx_d   = idx_q == 3'd7 ? 3'd0 : idx_q + 3'd1;
               state_d = idx_q == 3'd7 ? PARITY : DATA;
            end
            PARITY:  state_d = STOP;
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         endcase
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign bus.tx_out    = tx_q;
   assign bus.busy      = busy_q;
   assign bus.ready     = ~busy_q;
   assign bus.done_flag = done_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: table-driven frames checked by a line monitor against a scoreboard, plus corner sequences
module tb_uart_frame_tx;
   localparam int CPB = 4;
   localparam int FL  = 11 * CPB;
   typedef struct {
      logic [7:0] d;
      logic [1:0] pt;
      logic       p;
   } vec_t;
   logic clock = 1'b0, reset = 1'b1;
   int checks = 0, errors = 0;
   int done_cnt = 0, frames = 0, cyc = 0, end_cyc = 0, gap = 0, pos = 0;
   bit in_frame = 0;
   logic [10:0] got, last_frame;
   logic [10:0] sb[$];
   vec_t tbl[8];
   uart_frame_tx_if bus ();
   uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", n, a, e, $time);
      end
   endtask
   // line monitor: samples mid-bit, rebuilds the frame and checks it against the scoreboard
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (bus.done_flag) done_cnt++;
         chk("ready_xor_busy", bus.ready ^ bus.busy, 1);
         if (reset) in_frame = 0;
         else if (in_frame) begin
            if (pos % CPB == CPB / 2) got[pos / CPB] = bus.tx_out;
            if (pos == FL) begin
               chk("done_at_frame_end", bus.done_flag, 1);
               chk("idle_after_stop", bus.tx_out, 1);
               if (sb.size() == 0) chk("unexpected_frame", got, 0);
               else chk("frame", got, sb.pop_front());
               last_frame = got;
               frames++;
               end_cyc = cyc;
               in_frame = 0;
            end else chk("no_early_done", bus.done_flag, 0);
            pos++;
         end else if (bus.tx_out == 1'b0) begin
            in_frame = 1;
            pos = 1;
            gap = cyc - end_cyc;
         end
      end
   end
   task automatic send_byte(logic [7:0] d, logic [1:0] pt, logic p);
      int n = 0;
      while (!bus.ready && n < 200) begin @(negedge clock); n++; end
      chk("ready_before_send", bus.ready, 1);
      bus.send = 1'b1;
      bus.data_in = d;
      bus.parity_type = pt;
      sb.push_back({1'b1, p, d, 1'b0});
      @(negedge clock);
      bus.send = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || in_frame) && n < 200) begin @(negedge clock); n++; end
      chk("idle_timeout", n < 200, 1);
      @(negedge clock);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int db, fb, n;
      tbl[0] = '{8'hA5, 2'b10, 1'b0};
      tbl[1] = '{8'hA5, 2'b01, 1'b1};
      tbl[2] = '{8'h00, 2'b00, 1'b1};
      tbl[3] = '{8'h01, 2'b10, 1'b1};
      tbl[4] = '{8'hC3, 2'b11, 1'b1};
      tbl[5] = '{8'hFF, 2'b01, 1'b1};
      tbl[6] = '{8'h7F, 2'b10, 1'b1};
      tbl[7] = '{8'h3C, 2'b01, 1'b1};
      bus.send = 1'b0;
      bus.data_in = 8'h00;
      bus.parity_type = 2'b00;
      repeat (3) @(negedge clock);
      chk("reset_tx", bus.tx_out, 1);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("idle_tx", bus.tx_out, 1);
         chk("idle_busy", bus.busy, 0);
         chk("idle_ready", bus.ready, 1);
         chk("idle_done", bus.done_flag, 0);
      end
      for (int i = 0; i < 8; i++) begin
         db = done_cnt;
         send_byte(tbl[i].d, tbl[i].pt, tbl[i].p);
         chk("busy_after_accept", bus.busy, 1);
         wait_idle();
         chk("done_once", done_cnt - db, 1);
         if (i == 0) chk("frame_A5_even", last_frame, 11'h54A);
      end
      // a send arriving mid-frame must be dropped, not queued
      db = done_cnt;
      fb = frames;
      send_byte(8'h3C, 2'b10, 1'b0);
      repeat (10) @(negedge clock);
      bus.send = 1'b1;
      bus.data_in = 8'hFF;
      @(negedge clock);
      bus.send = 1'b0;
      wait_idle();
      repeat (20) @(negedge clock);
      chk("busy_prot_done", done_cnt - db, 1);
      chk("busy_prot_frames", frames - fb, 1);
      chk("busy_prot_line", bus.tx_out, 1);
      fb = frames;
      bus.send = 1'b1;
      bus.data_in = 8'h55;
      bus.parity_type = 2'b10;
      sb.push_back({1'b1, 1'b0, 8'h55, 1'b0});
      @(negedge clock);
      bus.data_in = 8'hAA;
      sb.push_back({1'b1, 1'b0, 8'hAA, 1'b0});
      n = 0;
      while (!bus.done_flag && n < 100) begin @(negedge clock); n++; end
      chk("b2b_done_seen", bus.done_flag, 1);
      @(negedge clock);
      bus.send = 1'b0;
      wait_idle();
      chk("b2b_frames", frames - fb, 2);
      chk("b2b_gap", gap, 1);
      // reset while DATA bit 4 (a 0) is on the line
      db = done_cnt;
      send_byte(8'h00, 2'b10, 1'b0);
      repeat (21) @(negedge clock);
      chk("pre_reset_tx", bus.tx_out, 0);
      #1 reset = 1'b1;
      #1;
      chk("reset_mid_tx", bus.tx_out, 1);
      chk("reset_mid_busy", bus.busy, 0);
      chk("reset_mid_ready", bus.ready, 1);
      sb.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (50) @(negedge clock);
      chk("reset_mid_no_done", done_cnt - db, 0);
      send_byte(8'h81, 2'b01, 1'b1);
      wait_idle();
      chk("after_reset_frame", last_frame, 11'h702);
      send_byte(8'hC3, 2'b10, 1'b0);
      wait_idle();
      chk("loop_raw_data", last_frame[8:1], 8'hC3);
      chk("loop_start", last_frame[0], 0);
      chk("loop_parity", last_frame[9], 0);
      chk("loop_stop", last_frame[10], 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
